// File: rtl/lea_pkg.sv
// Shared LEA datapath definitions: default widths and the block-packer state encoding.
`timescale 1ns/1ps
package lea_pkg;

  localparam int LEA_BYTE_W  = 8;
  localparam int LEA_BLOCK_W = 128;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_HOLD = 1'b1
  } pk_state_t;

endpackage

// File: rtl/lea_lane_place.sv
// Lane write-enable decoder: maps lane index and order to a one-hot lane mask.
`timescale 1ns/1ps
module lea_lane_place #(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [CW-1:0] i_idx,
  input  logic          i_msb,
  output logic [N-1:0]  o_mask
);

  logic [CW-1:0] w_pos;

  // MSB-first order mirrors the index so lane 0 lands in the top slot.
  assign w_pos = i_msb ? (CW'(N - 1) - i_idx) : i_idx;

  always_comb begin
    o_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pos == CW'(i)) o_mask[i] = 1'b1;
    end
  end

endmodule

// File: rtl/lea_block_packer.sv
// Stream-to-block packer: assembles IN_W-bit lanes into BLOCK_W-bit blocks with a
// one-block hold stage so lane intake continues while the output is back-pressured.
`timescale 1ns/1ps
module lea_block_packer
  import lea_pkg::*;
#(
  parameter  int IN_W    = LEA_BYTE_W,
  parameter  int BLOCK_W = LEA_BLOCK_W,
  localparam int N       = BLOCK_W / IN_W,
  localparam int CW      = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               msb_first,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic [CW-1:0]      out_count,
  output logic               out_last
);

  pk_state_t          r_state;
  pk_state_t          w_state_next;
  logic               r_in_ready;
  logic [CW-1:0]      r_cnt;
  logic               r_msb;
  logic [BLOCK_W-1:0] r_asm;
  logic [CW-1:0]      r_hold_cnt;
  logic               r_hold_last;
  logic               r_out_valid;
  logic [BLOCK_W-1:0] r_out_data;
  logic [CW-1:0]      r_out_count;
  logic               r_out_last;

  logic               w_msb_eff;
  logic [N-1:0]       w_mask;
  logic [BLOCK_W-1:0] w_asm_next;
  logic               w_accept;
  logic               w_close;
  logic               w_slot_free;

  // Order comes live from the port on lane 0, then from the latched copy.
  assign w_msb_eff   = (r_cnt == '0) ? msb_first : r_msb;
  assign w_accept    = in_valid && r_in_ready;
  assign w_close     = w_accept && ((r_cnt == CW'(N - 1)) || in_last);
  assign w_slot_free = !r_out_valid || out_ready;

  lea_lane_place #(
    .N  (N),
    .CW (CW)
  ) u_lane_place (
    .i_idx  (r_cnt),
    .i_msb  (w_msb_eff),
    .o_mask (w_mask)
  );

  always_comb begin
    w_asm_next = r_asm;
    for (int i = 0; i < N; i++) begin
      if (w_mask[i]) w_asm_next[i*IN_W +: IN_W] = in_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PK_FILL: if (w_close && !w_slot_free) w_state_next = PK_HOLD;
      PK_HOLD: if (w_slot_free) w_state_next = PK_FILL;
      default: w_state_next = PK_FILL;
    endcase
    if (clear) w_state_next = PK_FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PK_FILL;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == PK_FILL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_msb       <= 1'b0;
      r_asm       <= '0;
      r_hold_cnt  <= '0;
      r_hold_last <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_cnt       <= '0;
      r_asm       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (out_ready) r_out_valid <= 1'b0;
      case (r_state)
        PK_FILL: begin
          if (w_accept) begin
            if (r_cnt == '0) r_msb <= msb_first;
            if (w_close) begin
              r_cnt <= '0;
              if (w_slot_free) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_asm_next;
                r_out_count <= r_cnt + CW'(1);
                r_out_last  <= in_last;
                r_asm       <= '0;
              end else begin
                r_asm       <= w_asm_next;
                r_hold_cnt  <= r_cnt + CW'(1);
                r_hold_last <= in_last;
              end
            end else begin
              r_asm <= w_asm_next;
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        PK_HOLD: begin
          if (w_slot_free) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_asm;
            r_out_count <= r_hold_cnt;
            r_out_last  <= r_hold_last;
            r_asm       <= '0;
            r_cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_lea_block_packer.sv
// Scoreboard bench for lea_block_packer: a lane-list reference model predicts each block,
// a forked monitor compares every block the DUT hands over.
`timescale 1ns/1ps
module tb_lea_block_packer;

  localparam int IN_W = 8;
  localparam int BW   = 128;
  localparam int N    = 16;
  localparam int CW   = 5;

  typedef struct packed {
    logic [BW-1:0] d;
    logic [CW-1:0] c;
    logic          l;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            clear = 1'b0;
  logic            msb_first = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [IN_W-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BW-1:0]   out_data;
  logic [CW-1:0]   out_count;
  logic            out_last;

  lea_block_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .msb_first (msb_first),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int              n_chk = 0;
  int              n_fail = 0;
  int              stalls = 0;
  bit              rnd_mode = 1'b0;
  exp_t            exp_q[$];
  logic [IN_W-1:0] cur[$];
  logic            cur_msb = 1'b0;
  logic [IN_W-1:0] blk[N];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: collect accepted lanes per block, place them by the order of lane 0.
  task automatic model_accept(input logic [IN_W-1:0] d, input logic last, input logic msb);
    exp_t          e;
    logic [BW-1:0] dd;
    int            pos;
    if (cur.size() == 0) cur_msb = msb;
    cur.push_back(d);
    if (cur.size() == N || last) begin
      dd = '0;
      for (int k = 0; k < cur.size(); k++) begin
        pos = cur_msb ? (N - 1 - k) : k;
        dd[pos*IN_W +: IN_W] = cur[k];
      end
      e.d = dd;
      e.c = CW'(cur.size());
      e.l = last;
      exp_q.push_back(e);
      cur.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send_lane(input logic [IN_W-1:0] d, input logic last, input logic msb);
    bit acc;
    acc = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    msb_first = msb;
    for (int w = 0; w < 1000 && !acc; w++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        model_accept(d, last, msb);
      end else begin
        stalls++;
      end
      tick();
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: lane %h never accepted", d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic flush_model();
    exp_q.delete();
    cur.delete();
  endtask

  initial begin
    fork
      begin : monitor
        bit            prev_stall;
        logic [BW-1:0] pd;
        logic [CW-1:0] pc;
        logic          pl;
        exp_t          e;
        prev_stall = 1'b0;
        forever begin
          @(negedge clk);
          if (rst_n && !clear) begin
            if (prev_stall) begin
              chk("stable_valid", BW'(out_valid), BW'(1));
              chk("stable_data", out_data, pd);
              chk("stable_cnt_last", BW'({out_count, out_last}), BW'({pc, pl}));
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pc = out_count;
            pl = out_last;
            if (out_valid && out_ready) begin
              if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_block: got %h with nothing expected", out_data);
              end else begin
                e = exp_q.pop_front();
                chk("blk_data", out_data, e.d);
                chk("blk_count", BW'(out_count), BW'(e.c));
                chk("blk_last", BW'(out_last), BW'(e.l));
              end
            end
          end else begin
            prev_stall = 1'b0;
          end
        end
      end
      begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state, observed asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_count", BW'(out_count), BW'(0));
    chk("rst_out_last", BW'(out_last), BW'(0));
    #9 rst_n = 1'b1;
    tick();

    // Full block, LSB order, sustained throughput.
    out_ready = 1'b1;
    stalls = 0;
    for (int k = 0; k < N; k++) send_lane(IN_W'(k), 1'b0, 1'b0);
    @(negedge clk);
    chk("lsb_latency_valid", BW'(out_valid), BW'(1));
    chk("lsb_const", out_data, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("lsb_count", BW'(out_count), BW'(16));
    chk("lsb_no_stall", BW'(stalls), BW'(0));
    tick();

    // Full block, MSB order; msb_first toggles after lane 0 and must be ignored.
    for (int k = 0; k < N; k++) send_lane(IN_W'(k), 1'b0, (k == 0) ? 1'b1 : k[0]);
    @(negedge clk);
    chk("msb_const", out_data, 128'h000102030405060708090A0B0C0D0E0F);
    tick();

    // Partial block closed by in_last.
    for (int k = 0; k < 5; k++) send_lane(8'hA1 + IN_W'(k), (k == 4), 1'b0);
    @(negedge clk);
    chk("part_const", out_data, 128'h000000000000000000000000A5A4A3A2A1);
    chk("part_count", BW'(out_count), BW'(5));
    chk("part_last", BW'(out_last), BW'(1));
    tick();

    // Back-pressure: second block parks in HOLD behind the first.
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < N; k++) send_lane(IN_W'($urandom), 1'b0, b[0]);
    @(negedge clk);
    chk("hold_in_ready", BW'(in_ready), BW'(0));
    chk("hold_out_valid", BW'(out_valid), BW'(1));
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("hold_exit_valid", BW'(out_valid), BW'(1));
    chk("hold_exit_in_ready", BW'(in_ready), BW'(1));
    chk("hold_exit_data", out_data, (exp_q.size() != 0) ? exp_q[0].d : '1);
    tick();
    out_ready = 1'b1;
    tick();
    tick();

    // clear during lane 9 while an unread block sits in the output register.
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) send_lane(IN_W'($urandom), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) send_lane(IN_W'($urandom), 1'b0, 1'b1);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    flush_model();
    @(negedge clk);
    chk("clear_out_valid", BW'(out_valid), BW'(0));
    chk("clear_in_ready", BW'(in_ready), BW'(1));
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) send_lane(IN_W'(8'h40 + k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) send_lane(IN_W'(8'hC0 + k), (k == 2), 1'b1);
    tick();
    tick();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    for (int k = 0; k < N + 4; k++) send_lane(IN_W'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", BW'(out_valid), BW'(0));
    chk("arst_out_data", out_data, '0);
    chk("arst_out_count", BW'(out_count), BW'(0));
    chk("arst_out_last", BW'(out_last), BW'(0));
    chk("arst_in_ready", BW'(in_ready), BW'(1));
    flush_model();
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Randomised messages with random back-pressure.
    rnd_mode = 1'b1;
    for (int m = 0; m < 60; m++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        send_lane(IN_W'($urandom), (i == len - 1), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 7) == 0) tick();
      end
    end
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 300 && exp_q.size() != 0; w++) tick();
    chk("drain_empty", BW'(exp_q.size()), BW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
